// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: transmit-side frame controller for a UART serializer.
// Accepts parallel bytes, loads and steps the downstream serializer,
// computes optional parity and muxes start/data/parity/stop bits onto a
// registered, idle-high TX line. One line bit per CLK (baud clock) cycle.
module uart_tx_ctrl #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] P_DATA,
    input  logic              Data_Valid,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic              ser_done,
    input  logic              ser_data,
    output logic [DATA_W-1:0] P_DATA_ser,
    output logic              DATA_VALID_ser,
    output logic              ser_en,
    output logic              TX_OUT,
    output logic              Busy
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e state_q, state_d;

    // Frame configuration captured at accept time so upstream may change
    // P_DATA / PAR_EN / PAR_TYP freely while the frame is on the line.
    logic data_par_q;
    logic par_en_q;
    logic par_typ_q;
    logic par_bit;

    logic tx_q, tx_d;
    logic busy_q, busy_d;
    logic accept;

    // A new byte is taken only from IDLE or STOP; STOP acceptance gives
    // back-to-back frames with no idle gap on the line.
    assign accept = Data_Valid && !RST && ((state_q == StIdle) || (state_q == StStop));

    // Even parity of the data XOR the type bit gives even (0) / odd (1).
    assign par_bit = data_par_q ^ par_typ_q;

    // The serializer load value is a plain pass-through of the input byte.
    assign P_DATA_ser = P_DATA;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                state_d = StData;
            end
            StData: begin
                // ser_done marks the last data bit being presented.
                if (ser_done) begin
                    state_d = par_en_q ? StParity : StStop;
                end
            end
            StParity: begin
                state_d = StStop;
            end
            StStop: begin
                state_d = accept ? StStart : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output logic: serializer strobes and the next TX line value.
    always_comb begin
        DATA_VALID_ser = 1'b0;
        ser_en         = 1'b0;
        tx_d           = 1'b1;
        case (state_q)
            StIdle: begin
                DATA_VALID_ser = accept;
                tx_d           = 1'b1;
            end
            StStart: begin
                // First shift happens during the start bit so the first data
                // bit is already registered in the serializer on DATA entry.
                ser_en = !RST;
                tx_d   = 1'b0;
            end
            StData: begin
                ser_en = !RST && !ser_done;
                tx_d   = ser_data;
            end
            StParity: begin
                tx_d = par_bit;
            end
            StStop: begin
                DATA_VALID_ser = accept;
                tx_d           = 1'b1;
            end
            default: begin
                tx_d = 1'b1;
            end
        endcase
    end

    // Busy looks ahead one state so it is registered alongside the state.
    assign busy_d = (state_d == StStart) || (state_d == StData) || (state_d == StParity);

    // Frame configuration capture on accept.
    always_ff @(posedge CLK) begin
        if (RST) begin
            data_par_q <= 1'b0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
        end else if (accept) begin
            data_par_q <= ^P_DATA;
            par_en_q   <= PAR_EN;
            par_typ_q  <= PAR_TYP;
        end
    end

    // Registered TX line and Busy flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            busy_q <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Testbench for uart_tx_ctrl: drives directed and random frames, models the
// downstream serializer, and checks every cycle against a timeline model
// that derives line bits, Busy and strobes from the accept cycle arithmetic.
module tb_uart_tx_ctrl;

    localparam int DATA_W = 8;
    localparam int NCYC   = 4096;

    logic              CLK;
    logic              RST;
    logic [DATA_W-1:0] P_DATA;
    logic              Data_Valid;
    logic              PAR_EN;
    logic              PAR_TYP;
    logic              ser_done;
    logic              ser_data;
    logic [DATA_W-1:0] P_DATA_ser;
    logic              DATA_VALID_ser;
    logic              ser_en;
    logic              TX_OUT;
    logic              Busy;

    uart_tx_ctrl #(.DATA_W(DATA_W)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .P_DATA         (P_DATA),
        .Data_Valid     (Data_Valid),
        .PAR_EN         (PAR_EN),
        .PAR_TYP        (PAR_TYP),
        .ser_done       (ser_done),
        .ser_data       (ser_data),
        .P_DATA_ser     (P_DATA_ser),
        .DATA_VALID_ser (DATA_VALID_ser),
        .ser_en         (ser_en),
        .TX_OUT         (TX_OUT),
        .Busy           (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Serializer: load on strobe, registered LSB-first output on each enabled
    // shift, done pulses the cycle after the DATA_W-th enabled shift.
    logic [DATA_W-1:0] sh_q;
    int                scnt_q;
    always_ff @(posedge CLK) begin
        if (RST) begin
            sh_q     <= '0;
            scnt_q   <= 0;
            ser_done <= 1'b0;
            ser_data <= 1'b0;
        end else if (DATA_VALID_ser) begin
            sh_q     <= P_DATA_ser;
            scnt_q   <= 0;
            ser_done <= 1'b0;
        end else if (ser_en) begin
            ser_data <= sh_q[0];
            sh_q     <= sh_q >> 1;
            scnt_q   <= scnt_q + 1;
            ser_done <= (scnt_q == DATA_W - 1);
        end else begin
            ser_done <= 1'b0;
        end
    end

    // Reference timeline, indexed by cycle number.
    logic exp_line [NCYC];
    logic exp_busy [NCYC];
    int   cyc;
    int   t0;
    int   next_ready;
    bit   regs_valid;
    int   n_checks;
    int   n_pass;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle %0d: observed %0h, expected %0h", tag, cyc, obs, exp);
    endtask

    // One clock cycle: drive inputs, check against the timeline, then update.
    task automatic step(input logic rst, input logic dv, input logic [DATA_W-1:0] d,
                        input logic pe, input logic pt);
        int  c;
        int  len;
        bit  acc;
        bit  en_exp;
        @(negedge CLK);
        RST        = rst;
        Data_Valid = dv;
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        #1;
        c      = cyc;
        acc    = !rst && dv && (c >= next_ready);
        en_exp = !rst && (c >= t0 + 1) && (c <= t0 + DATA_W);
        check("data_valid_ser", DATA_VALID_ser, acc);
        check("ser_en", ser_en, en_exp);
        check("p_data_ser", P_DATA_ser, d);
        if (regs_valid) begin
            check("tx_out", TX_OUT, exp_line[c]);
            check("busy", Busy, exp_busy[c]);
        end
        if (!rst && c == t0 + 2) begin
            check("ser_done_on_data_entry", ser_done, 1'b0);
        end
        if (rst) begin
            regs_valid = 1'b1;
            t0         = -100;
            next_ready = c + 1;
            for (int k = c + 1; k < NCYC; k++) begin
                exp_line[k] = 1'b1;
                exp_busy[k] = 1'b0;
            end
        end else if (acc) begin
            len        = DATA_W + 2 + int'(pe);
            t0         = c;
            next_ready = c + len;
            exp_line[c + 2] = 1'b0;
            for (int i = 0; i < DATA_W; i++) begin
                exp_line[c + 3 + i] = d[i];
            end
            if (pe) begin
                exp_line[c + 3 + DATA_W] = (^d) ^ pt;
            end
            exp_line[c + len + 1] = 1'b1;
            for (int k = c + 1; k < c + len; k++) begin
                exp_busy[k] = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, DATA_W'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    // Waits until the model is ready (optionally with ignored requests),
    // adds gap idle cycles, then issues the accepted request.
    task automatic send(input logic [DATA_W-1:0] d, input logic pe, input logic pt,
                        input int gap, input bit noisy);
        int guard;
        guard = 0;
        while (cyc < next_ready && guard < 64) begin
            step(1'b0, noisy ? 1'($urandom) : 1'b0, DATA_W'($urandom), 1'($urandom),
                 1'($urandom));
            guard++;
        end
        if (guard >= 64) begin
            n_checks++;
            $error("FAIL send_wait: observed not ready after %0d cycles, expected ready", guard);
        end
        for (int i = 0; i < gap; i++) begin
            step(1'b0, 1'b0, DATA_W'($urandom), 1'($urandom), 1'($urandom));
        end
        step(1'b0, 1'b1, d, pe, pt);
    endtask

    initial begin
        int rst_at;
        cyc        = 0;
        t0         = -100;
        next_ready = NCYC;
        regs_valid = 1'b0;
        n_checks   = 0;
        n_pass     = 0;
        RST        = 1'b1;
        Data_Valid = 1'b0;
        P_DATA     = '0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        for (int k = 0; k < NCYC; k++) begin
            exp_line[k] = 1'b1;
            exp_busy[k] = 1'b0;
        end

        // Reset held with a pending request.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0);
        end

        // Plain frame, then parity variants.
        send(8'hA5, 1'b0, 1'b0, 0, 1'b0);
        idle(14);
        send(8'hA5, 1'b1, 1'b0, 2, 1'b0);
        send(8'hA5, 1'b1, 1'b1, 2, 1'b0);
        send(8'h07, 1'b1, 1'b0, 2, 1'b0);
        idle(14);

        // Back-to-back, second request lands in the STOP cycle.
        send(8'h55, 1'b0, 1'b0, 1, 1'b0);
        send(8'h0F, 1'b0, 1'b0, 0, 1'b0);
        idle(14);

        // Request held high with 0xFF across a 0x00 frame.
        send(8'h00, 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        end
        idle(14);

        // Reset during the 4th data bit on the line, then a fresh frame.
        send(8'hC3, 1'b1, 1'b1, 0, 1'b0);
        while (cyc < t0 + 6) begin
            idle(1);
        end
        rst_at = cyc;
        step(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1);
        send(8'h3C, 1'b0, 1'b0, 0, 1'b0);
        idle(14);
        if (rst_at + 1 < 0) begin
            idle(1);
        end

        // Random frames with random gaps and ignored requests while busy.
        for (int f = 0; f < 60; f++) begin
            send(DATA_W'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                 1'b1);
        end
        idle(16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Transmit-side frame controller sitting directly upstream of the UART serializer.
- Accepts parallel bytes, loads and steps the serializer, computes optional parity, and muxes start, data, parity and stop bits onto the registered TX line.
- One bit per CLK cycle; CLK is the TX baud clock.

Parameters:
DATA_W, 8, data bits per frame; must equal the serializer bit count (its ser_done count).

Ports:
CLK  in  1  TX baud clock, rising edge.
RST  in  1  synchronous, active-high reset.
P_DATA  in  DATA_W  byte to transmit.
Data_Valid  in  1  upstream request; accepted only when ready (see Behaviour).
PAR_EN  in  1  1 = insert parity bit.
PAR_TYP  in  1  0 = even, 1 = odd.
ser_done  in  1  from serializer: high the cycle after its DATA_W-th enabled shift.
ser_data  in  1  from serializer: current registered data bit, LSB first.
P_DATA_ser  out  DATA_W  load value to serializer (combinational pass-through of P_DATA).
DATA_VALID_ser  out  1  serializer load strobe (combinational).
ser_en  out  1  serializer shift enable (combinational).
TX_OUT  out  1  serial line, registered, idle high.
Busy  out  1  registered; 1 = new Data_Valid will be ignored.

Behaviour:
- Reset: state=IDLE, TX_OUT=1, Busy=0, latched parity/config cleared. DATA_VALID_ser=0 and ser_en=0 while RST=1. Mid-frame reset aborts the frame; TX_OUT=1 from the next edge. The system reset also clears the serializer.
- States: IDLE, START, DATA, PARITY, STOP.
- Accept condition: Data_Valid=1 and state is IDLE or STOP.
  - On accept: DATA_VALID_ser=1 that cycle; P_DATA_ser=P_DATA.
  - At the edge, latch par_bit = (^P_DATA) ^ PAR_TYP, PAR_EN and PAR_TYP, then go to START.
  - Data_Valid in START, DATA or PARITY is ignored; no load strobe.
- IDLE: no accept -> stay.
- START: ser_en=1 for one cycle, then DATA.
- DATA: ser_en = ~ser_done. When ser_done=1: go to PARITY if latched PAR_EN, else STOP.
  - With the serializer contract, DATA lasts exactly DATA_W cycles: the DATA_W enables are START plus the first DATA_W-1 DATA cycles.
- PARITY: one cycle, then STOP.
- STOP: accept -> START (back-to-back, no idle gap); else IDLE.
- TX_OUT register, loaded from the current state: IDLE 1, START 0, DATA ser_data, PARITY latched par_bit, STOP 1. Each line bit therefore appears one cycle after its state cycle.
- Busy register: Busy <= (next_state in {START, DATA, PARITY}). Busy is low during STOP so upstream may queue the next byte.
- Timeline, accept edge = T0:
  - State: START at T1, DATA T2..T(1+DATA_W), PARITY next if enabled, then STOP.
  - TX_OUT: start bit at T2, data bits T3..T(2+DATA_W) LSB first, parity (if enabled), then stop.
  - Frame length on the line: DATA_W+2 cycles, plus 1 with parity.
- ser_en is never asserted outside START/DATA. DATA_VALID_ser is never asserted outside IDLE/STOP.
- If ser_done is high on entry to DATA, the block goes straight on to PARITY/STOP. This is a protocol violation and is flagged by bench assertion only.

Test Plan:
1. Reset: RST=1 for 3 cycles with Data_Valid=1 -> TX_OUT=1, Busy=0, DATA_VALID_ser=0, ser_en=0 throughout.
2. P_DATA=0xA5, PAR_EN=0, accept at T0 -> TX_OUT T2..T11 = 0,1,0,1,0,0,1,0,1,1. Busy=1 T1..T9. Back to IDLE after the stop bit.
3. P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0 at T11, stop 1 at T12. Repeat with PAR_TYP=1 -> parity 1. P_DATA=0x07 even -> parity 1.
4. Back-to-back: 0x55 then 0x0F, each Data_Valid asserted during the previous STOP -> stop bit immediately followed by the next start bit; no idle cycle; both frames bit-exact.
5. Data_Valid=1 with P_DATA=0xFF held throughout a 0x00 frame -> 0x00 frame unaltered; DATA_VALID_ser pulses only in IDLE/STOP cycles; 0xFF is sent next.
6. RST asserted during the 4th data bit -> TX_OUT=1 the following cycle, Busy=0, state IDLE. A new 0x3C frame then transmits correctly.
